// File: rtl/led_matrix_scanner_pkg.sv
// Shared types and constants for the 2-digit, 5x7 LED matrix column scanner.
package led_matrix_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BLANK  = 2'd1,
        SAMPLE = 2'd2,
        SHOW   = 2'd3
    } scan_state_e;

    localparam int NUM_COLS   = 5;
    localparam int NUM_ROWS   = 7;
    localparam int NUM_DIGITS = 2;

    localparam logic [NUM_COLS-1:0] COL_OFF = 5'b11111;

    // Counter width able to hold the larger of the two phase lengths.
    function automatic int timer_width(input int blank_cycles, input int dwell_cycles);
        int max_cycles;
        max_cycles = (blank_cycles > dwell_cycles) ? blank_cycles : dwell_cycles;
        return $clog2(max_cycles) + 1;
    endfunction

endpackage

// File: rtl/led_matrix_scanner_timer.sv
// Loadable down-counter that saturates at zero and flags terminal count.
module led_scan_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Holds at zero instead of wrapping so an unloaded timer stays terminal.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/led_matrix_scanner.sv
// Scans ten column slots (2 digits x 5 columns) of a 5x7 LED matrix with
// blanking, a one-cycle row sample and a dwell phase per column.
module led_matrix_scanner
    import led_matrix_scanner_pkg::*;
#(
    parameter int BLANK_CYCLES = 4,
    parameter int DWELL_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                enable,
    input  logic [NUM_ROWS-1:0] selected_values,
    output logic                bin_number_sel,
    output logic [2:0]          col_index,
    output logic [NUM_COLS-1:0] col_n,
    output logic [NUM_ROWS-1:0] rows,
    output logic                frame_done
);

    localparam int CW = timer_width(BLANK_CYCLES, DWELL_CYCLES);
    // Timer is loaded with length-1 so terminal count lands on the last cycle.
    localparam logic [CW-1:0] BLANK_LOAD = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);

    scan_state_e         state_q, state_d;
    logic                digit_q, digit_d;
    logic [2:0]          col_q, col_d;
    logic [NUM_COLS-1:0] col_n_q, col_n_d;
    logic [NUM_ROWS-1:0] rows_q, rows_d;
    logic                frame_done_q, frame_done_d;
    logic                timer_load;
    logic [CW-1:0]       timer_value;
    logic                timer_tc;

    led_scan_timer #(
        .WIDTH(CW)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (timer_load),
        .load_value_i(timer_value),
        .tc_o        (timer_tc)
    );

    always_comb begin
        state_d      = state_q;
        digit_d      = digit_q;
        col_d        = col_q;
        rows_d       = '0;
        frame_done_d = 1'b0;
        timer_load   = 1'b0;
        timer_value  = '0;

        if (state_q != IDLE && !enable) begin
            state_d    = IDLE;
            digit_d    = 1'b0;
            col_d      = '0;
            timer_load = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    digit_d = 1'b0;
                    col_d   = '0;
                    if (enable) begin
                        state_d     = BLANK;
                        timer_load  = 1'b1;
                        timer_value = BLANK_LOAD;
                    end
                end
                BLANK: begin
                    if (timer_tc) begin
                        state_d    = SAMPLE;
                        timer_load = 1'b1;
                    end
                end
                SAMPLE: begin
                    state_d     = SHOW;
                    rows_d      = selected_values;
                    timer_load  = 1'b1;
                    timer_value = DWELL_LOAD;
                end
                SHOW: begin
                    rows_d = rows_q;
                    if (timer_tc) begin
                        state_d     = BLANK;
                        rows_d      = '0;
                        timer_load  = 1'b1;
                        timer_value = BLANK_LOAD;
                        if (col_q == 3'(NUM_COLS - 1)) begin
                            col_d   = '0;
                            digit_d = ~digit_q;
                            frame_done_d = (digit_q == 1'(NUM_DIGITS - 1));
                        end else begin
                            col_d = col_q + 3'd1;
                        end
                    end
                end
                default: begin
                    state_d    = IDLE;
                    timer_load = 1'b1;
                end
            endcase
        end
    end

    // Column drive is decoded from the next state so it switches on the entry edge.
    generate
        for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col_drive
            assign col_n_d[gi] = ~((state_d == SHOW) && (col_d == 3'(gi)));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            digit_q      <= 1'b0;
            col_q        <= '0;
            col_n_q      <= COL_OFF;
            rows_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            digit_q      <= digit_d;
            col_q        <= col_d;
            col_n_q      <= col_n_d;
            rows_q       <= rows_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bin_number_sel = digit_q;
    assign col_index      = col_q;
    assign col_n          = col_n_q;
    assign rows           = rows_q;
    assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench: a directed timing table, an arithmetic slot/phase
// reference model under random row data, enable drop and async reset cases.
module tb_led_matrix_scanner;

    logic       clk;
    logic       reset_n;
    logic       en0, en1;
    logic       echo0;
    logic [6:0] sel_drv0;
    logic [6:0] sel0, sel1;
    logic       bsel0, bsel1;
    logic [2:0] col0, col1;
    logic [4:0] coln0, coln1;
    logic [6:0] rows0, rows1;
    logic       fd0, fd1;
    logic [16:0] obs0, obs1;

    int checks;
    int failures;

    localparam logic [16:0] OBS_BLANK = 17'h00F80;

    led_matrix_scanner #(.BLANK_CYCLES(2), .DWELL_CYCLES(3)) dut (
        .clk(clk), .reset_n(reset_n), .enable(en0), .selected_values(sel0),
        .bin_number_sel(bsel0), .col_index(col0), .col_n(coln0),
        .rows(rows0), .frame_done(fd0)
    );

    led_matrix_scanner #(.BLANK_CYCLES(1), .DWELL_CYCLES(1)) dut_min (
        .clk(clk), .reset_n(reset_n), .enable(en1), .selected_values(sel1),
        .bin_number_sel(bsel1), .col_index(col1), .col_n(coln1),
        .rows(rows1), .frame_done(fd1)
    );

    // Row mux stand-in: either echoes the current slot or passes driven data.
    always_comb sel0 = echo0 ? {3'b000, bsel0, col0} : sel_drv0;
    assign sel1 = {3'b000, bsel1, col1};

    assign obs0 = {fd0, bsel0, col0, coln0, rows0};
    assign obs1 = {fd1, bsel1, col1, coln1, rows1};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_inv(input logic [16:0] o);
        int zeros;
        zeros = 5 - $countones(o[11:7]);
        chk("onehot", 32'(zeros <= 1), 32'd1);
        chk("blank_rows", 32'((o[11:7] == 5'h1F) && (o[6:0] != 7'd0)), 32'd0);
    endtask

    // Expected outputs from the position in the frame: c counts cycles since
    // the edge that first saw enable high.
    function automatic logic [16:0] model(input int c, input int b, input int d,
                                          input logic [6:0] smp);
        int p_len, k, s, p;
        logic dig, fd;
        logic [2:0] col;
        logic [4:0] cn;
        logic [6:0] r;
        p_len = b + 1 + d;
        k     = c - 1;
        s     = (k / p_len) % 10;
        p     = k % p_len;
        dig   = (s >= 5);
        col   = 3'(s % 5);
        fd    = (k > 0) && (k % (10 * p_len) == 0);
        if (p > b) begin
            cn = ~(5'd1 << col);
            r  = smp;
        end else begin
            cn = 5'h1F;
            r  = 7'd0;
        end
        return {fd, dig, col, cn, r};
    endfunction

    task automatic run_model(input int which, input int ncyc, input bit rnd,
                             input int b, input int d);
        logic [6:0]  smp;
        logic [6:0]  v;
        logic [16:0] exp_o;
        logic [16:0] act;
        int p;
        smp = '0;
        v   = sel_drv0;
        if (which == 0) begin
            echo0 = !rnd;
            en0   = 1'b1;
        end else begin
            en1 = 1'b1;
        end
        tick();
        for (int c = 1; c <= ncyc; c++) begin
            exp_o = model(c, b, d, smp);
            act   = (which == 0) ? obs0 : obs1;
            chk($sformatf("slot_u%0d_c%0d", which, c), 32'(act), 32'(exp_o));
            chk_inv(act);
            p = (c - 1) % (b + 1 + d);
            if (rnd) begin
                v        = sel_drv0 ^ 7'($urandom_range(1, 127));
                sel_drv0 = v;
            end
            if (p == b) smp = rnd ? v : {3'b000, exp_o[15], exp_o[14:12]};
            if (c != ncyc) tick();
        end
        $display("run unit=%0d cycles=%0d rnd=%0d checks=%0d", which, ncyc, rnd, checks);
    endtask

    typedef struct {
        logic       en;
        logic [6:0] sel;
        logic [4:0] coln;
        logic [6:0] rows;
        logic [3:0] slot;
        logic       fd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        en0      = 1'b0;
        en1      = 1'b0;
        echo0    = 1'b0;
        sel_drv0 = '0;

        // Each row: inputs held through the next edge, outputs seen after it.
        tbl[0] = '{1'b1, 7'h11, 5'h1F, 7'h00, 4'h0, 1'b0};
        tbl[1] = '{1'b1, 7'h11, 5'h1F, 7'h00, 4'h0, 1'b0};
        tbl[2] = '{1'b1, 7'h11, 5'h1F, 7'h00, 4'h0, 1'b0};
        tbl[3] = '{1'b1, 7'h55, 5'h1E, 7'h55, 4'h0, 1'b0};
        tbl[4] = '{1'b1, 7'h2A, 5'h1E, 7'h55, 4'h0, 1'b0};
        tbl[5] = '{1'b1, 7'h7F, 5'h1E, 7'h55, 4'h0, 1'b0};
        tbl[6] = '{1'b1, 7'h2A, 5'h1F, 7'h00, 4'h1, 1'b0};
        tbl[7] = '{1'b0, 7'h2A, 5'h1F, 7'h00, 4'h0, 1'b0};
        tbl[8] = '{1'b0, 7'h33, 5'h1F, 7'h00, 4'h0, 1'b0};
        tbl[9] = '{1'b1, 7'h33, 5'h1F, 7'h00, 4'h0, 1'b0};

        tick();
        tick();
        chk("reset_u0", 32'(obs0), 32'(OBS_BLANK));
        chk("reset_u1", 32'(obs1), 32'(OBS_BLANK));
        reset_n = 1'b1;
        tick();
        chk("idle_u0", 32'(obs0), 32'(OBS_BLANK));

        for (int i = 0; i < 10; i++) begin
            en0      = tbl[i].en;
            sel_drv0 = tbl[i].sel;
            tick();
            chk($sformatf("tbl%0d_col_n", i), 32'(coln0), 32'(tbl[i].coln));
            chk($sformatf("tbl%0d_rows", i), 32'(rows0), 32'(tbl[i].rows));
            chk($sformatf("tbl%0d_slot", i), 32'({bsel0, col0}), 32'(tbl[i].slot));
            chk($sformatf("tbl%0d_fd", i), 32'(fd0), 32'(tbl[i].fd));
            $display("vec %0d en=%0d sel=%h col_n=%b rows=%h slot=%0d,%0d fd=%0d",
                     i, tbl[i].en, tbl[i].sel, coln0, rows0, bsel0, col0, fd0);
        end
        en0 = 1'b0;
        tick();
        tick();

        // Two full frames with echo rows: slot order, row contents, frame_done.
        run_model(0, 130, 1'b0, 2, 3);
        en0 = 1'b0;
        tick();
        tick();

        // Row data changing every cycle must only be captured in SAMPLE.
        run_model(0, 70, 1'b1, 2, 3);
        en0 = 1'b0;
        tick();
        tick();

        // Drop enable in the first SHOW cycle of slot (0,3), then re-enable.
        run_model(0, 22, 1'b0, 2, 3);
        chk("pre_drop_slot", 32'({bsel0, col0}), 32'd3);
        en0 = 1'b0;
        tick();
        chk("drop_en", 32'(obs0), 32'(OBS_BLANK));
        run_model(0, 12, 1'b0, 2, 3);
        en0 = 1'b0;
        tick();
        tick();

        // Asynchronous reset in the middle of SHOW.
        run_model(0, 5, 1'b0, 2, 3);
        chk("pre_rst_lit", 32'(coln0), 32'h1E);
        #3;
        reset_n = 1'b0;
        #1;
        chk("async_rst", 32'(obs0), 32'(OBS_BLANK));
        tick();
        chk("rst_hold", 32'(obs0), 32'(OBS_BLANK));
        reset_n = 1'b1;
        run_model(0, 8, 1'b0, 2, 3);
        en0 = 1'b0;
        tick();

        // Shortest legal phases: 3 cycles per slot, 30 per frame.
        run_model(1, 65, 1'b0, 1, 1);
        en1 = 1'b0;
        tick();
        chk("min_idle", 32'(obs1), 32'(OBS_BLANK));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_matrix_scanner.md
LED_MATRIX_SCANNER -- requirements
Module: led_matrix_scanner

Interface
REQ-001 Parameter BLANK_CYCLES, default 4, all-off cycles before each column; legal range 1..255.
REQ-002 Parameter DWELL_CYCLES, default 1000, cycles each column stays lit; legal range 1..65535.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  scanning enabled when high.
REQ-006 selected_values  input  7  row pattern from the 2x1 row mux for the current digit and column; bit n drives row n.
REQ-007 bin_number_sel  output  1  digit select to the row mux; 0 = digit 0, 1 = digit 1.
REQ-008 col_index  output  3  column index 0..4 to both digit decoders.
REQ-009 col_n  output  5  active-low one-hot column drive.
REQ-010 rows  output  7  active-high row drive.
REQ-011 frame_done  output  1  one-cycle pulse at the end of each full 10-slot frame.

Function
REQ-012 A slot is the pair {bin_number_sel, col_index}. Slots SHALL run in order (0,0),(0,1)..(0,4),(1,0)..(1,4), then wrap to (0,0).
REQ-013 States: IDLE, BLANK, SAMPLE, SHOW.
REQ-014 IDLE: col_n=5'b11111, rows=0, slot=(0,0). Go to BLANK when enable=1.
REQ-015 BLANK: lasts exactly BLANK_CYCLES cycles with col_n=5'b11111 and rows=0. bin_number_sel/col_index already show the upcoming slot. Then go to SAMPLE.
REQ-016 SAMPLE: lasts exactly 1 cycle; at its closing edge selected_values SHALL be registered into rows. col_n stays all-ones. Then go to SHOW.
REQ-017 SHOW: lasts exactly DWELL_CYCLES cycles. col_n[col_index]=0 and all other bits are 1; rows holds the sampled value; slot outputs stay stable.
REQ-018 At the end of SHOW the slot SHALL advance and the block SHALL go to BLANK.
REQ-019 At the end of SHOW for slot (1,4), frame_done SHALL be 1 for exactly the first BLANK cycle of slot (0,0).
REQ-020 Frame period SHALL be 10*(BLANK_CYCLES+1+DWELL_CYCLES) cycles.
REQ-021 Latency: with enable first sampled high at edge k, the first column SHALL be lit from cycle k+BLANK_CYCLES+2.
REQ-022 enable low in any non-IDLE state: next state IDLE. col_n goes all-ones and rows goes to 0 at the same edge. Slot resets to (0,0). No frame_done pulse.
REQ-023 enable toggling while in IDLE SHALL have no effect other than REQ-014.
REQ-024 col_n SHALL never have more than one bit low. rows SHALL be 0 whenever col_n is all-ones.
REQ-025 Changes on selected_values outside the SAMPLE cycle SHALL NOT affect rows.
REQ-026 The cycle counter SHALL be $clog2(max(BLANK_CYCLES,DWELL_CYCLES))+1 bits wide, reload on each state entry, and never wrap.

Reset
REQ-027 While reset_n is low: state=IDLE, bin_number_sel=0, col_index=0, col_n=5'b11111, rows=0, frame_done=0, counter=0.
REQ-028 Reset assertion mid-SHOW SHALL blank the outputs immediately, without waiting for clk.
REQ-029 After reset_n rises, the first slot SHALL be (0,0).

Structure
REQ-030 A shared package SHALL hold the state enum, NUM_COLS=5, NUM_ROWS=7, NUM_DIGITS=2 and COL_OFF=5'b11111.
REQ-031 The down-counter with load and terminal-count SHALL be a sub-module, led_scan_timer; FSM and slot logic stay in led_matrix_scanner.

Verification (BLANK_CYCLES=2, DWELL_CYCLES=3 unless noted)
REQ-032 Reset, then enable=1 at edge 0 -> BLANK in cycles 1-2, SAMPLE in cycle 3, col_n=5'b11110 in cycles 4-6, slot (0,0).
REQ-033 Full frame with selected_values={bin_number_sel,col_index} echo model -> 10 slots in REQ-012 order, rows match each slot, frame_done high once every 60 cycles.
REQ-034 Drop enable during SHOW of slot (0,3) -> next cycle col_n=5'b11111, rows=0, slot (0,0). Re-enable -> timing as in REQ-032.
REQ-035 Assert reset_n low asynchronously mid-SHOW -> outputs blank before the next clk edge, and all REQ-027 values hold.
REQ-036 Toggle selected_values every cycle -> rows changes only one cycle after SAMPLE. The one-hot and blanking checks of REQ-024 hold on every cycle.
REQ-037 BLANK_CYCLES=1, DWELL_CYCLES=1 -> period 3 cycles per slot, 30 per frame, no counter wrap.
